// File: rtl/lsu_if.sv
// ============================================================================
// lsu_if : request/response and data-memory signal bundle for the LSU
// Rev 1.0
// ============================================================================
`default_nettype none

interface lsu_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// lsu : byte/half/word load-store unit with read-modify-write sub-word stores
// Optional: LSU_MISALIGN_TRAP_EN traps misaligned halfword/word requests.
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu #(
  parameter int ADDR_W = 10
) (
  input  wire logic clk,
  input  wire logic rst,
  lsu_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LD   = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4
  } state_t;

  state_t            r_state, w_next;
  logic              r_store, r_uns;
  logic [1:0]        r_size, r_off;
  logic [15:0]       r_wdata;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [31:0]       r_mem_wdata, r_resp_rdata;
  logic              r_resp_valid, r_resp_err;

  logic              w_ready, w_accept, w_mis, w_word;
  logic [4:0]        w_sh;
  logic [31:0]       w_shift, w_load, w_merge;
  logic [15:0]       w_half;

  assign w_word   = bus.req_size[1];
  assign w_ready  = (r_state == IDLE) & ~rst;
  assign w_accept = bus.req_valid & w_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                 (w_word & (bus.req_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_mis)                          w_next = IDLE;
          else if (bus.req_store && w_word)   w_next = WR;
          else                                w_next = RD;
        end
      end
      RD:      w_next = r_store ? MRG : LD;
      LD:      w_next = IDLE;
      MRG:     w_next = WR;
      WR:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Halfword lanes select on offset bit 1 only, so an untrapped odd address stays in its lane.
  assign w_sh    = {r_off, 3'b000};
  assign w_shift = bus.mem_rdata >> w_sh;
  assign w_half  = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    w_load = bus.mem_rdata;
    case (r_size)
      2'b00:   w_load = r_uns ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = bus.mem_rdata;
    if (r_size == 2'b00)
      w_merge = (bus.mem_rdata & ~(32'h0000_00FF << w_sh)) | ({24'd0, r_wdata[7:0]} << w_sh);
    else if (r_off[1])
      w_merge = {r_wdata, bus.mem_rdata[15:0]};
    else
      w_merge = {bus.mem_rdata[31:16], r_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_store      <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_wdata      <= 16'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_store <= bus.req_store;
            r_size  <= bus.req_size;
            r_uns   <= bus.req_unsigned;
            r_off   <= bus.req_addr[1:0];
            r_wdata <= bus.req_wdata[15:0];
            if (w_mis) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_mem_addr <= bus.req_addr[ADDR_W-1:2];
              if (bus.req_store && w_word) r_mem_wdata <= bus.req_wdata;
            end
          end
        end
        LD: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load;
        end
        MRG: r_mem_wdata <= w_merge;
        WR: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.mem_read   = (r_state == RD);
  assign bus.mem_write  = (r_state == WR);
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// tb_lsu : randomized and directed bench for lsu against a byte-array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(10)) bus ();
  lsu #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  // Word-wide memory attached to the DUT, plus a preload port for the bench.
  logic [31:0] mem [256];
  logic [31:0] mem_q;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a  = 8'd0;
  logic [31:0] pl_d  = 32'd0;
  assign bus.mem_rdata = mem_q;

  always @(posedge clk) begin
    if (pl_en)              mem[pl_a] <= pl_d;
    else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)       mem_q <= mem[bus.mem_addr];
  end

  // Reference: byte-addressed memory image.
  logic [7:0] rb [1024];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [9:0] a, input logic [1:0] sz);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [9:0] a, input logic [1:0] sz, input bit un);
    int n, base;
    longint v;
    n = nbytes(sz);
    base = int'(a) - (int'(a) % n);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(rb[base+i]) << (8*i));
    if (!un && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [9:0] a);
    int b;
    b = int'(a) - (int'(a) % 4);
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  task automatic model_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n, base;
    n = nbytes(sz);
    base = int'(a) - (int'(a) % n);
    for (int i = 0; i < n; i++) rb[base+i] = wd[8*i +: 8];
  endtask

  task automatic preload(input logic [7:0] wa, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = wa; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) rb[int'(wa)*4+i] = d[8*i +: 8];
  endtask

  // Issues one request and records what the DUT did, cycle-numbered from acceptance.
  task automatic xact(input bit st, input logic [1:0] sz, input bit un, input logic [9:0] a,
                      input logic [31:0] wd, output int lat, output int rdc, output int wrc,
                      output logic [31:0] rdata, output logic err, output logic [7:0] radr,
                      output logic [7:0] wadr, output logic [31:0] wdat, output bit ovl);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
    bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_store = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_addr = 10'($urandom); bus.req_wdata = $urandom;
    lat = -1; rdc = -1; wrc = -1; ovl = 1'b0;
    rdata = 32'hx; err = 1'bx; radr = 8'hx; wadr = 8'hx; wdat = 32'hx;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_write) ovl = 1'b1;
      if (bus.mem_read && rdc < 0) begin rdc = c; radr = bus.mem_addr; end
      if (bus.mem_write && wrc < 0) begin wrc = c; wadr = bus.mem_addr; wdat = bus.mem_wdata; end
      if (bus.resp_valid) begin lat = c; rdata = bus.resp_rdata; err = bus.resp_err; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
    nvec++;
    if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      nerr++; $display("FAIL reset_flags: got %b want 0000", {bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write});
    end
    nvec++;
    if ({bus.resp_rdata, bus.mem_wdata, bus.mem_addr} !== 72'd0) begin
      nerr++; $display("FAIL reset_data: got %h/%h/%h want 0", bus.resp_rdata, bus.mem_wdata, bus.mem_addr);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL ready_after_reset: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_directed();
    int lat, rdc, wrc; logic [31:0] rd, wdat; logic err; logic [7:0] radr, wadr; bit ovl;
    xact(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    model_store(10'h010, 2'b10, 32'hDEADBEEF);
    nvec++;
    if (wrc !== 1 || wadr !== 8'h04 || wdat !== 32'hDEADBEEF || lat !== 2) begin
      nerr++; $display("FAIL word_store: got wr@%0d addr %h data %h lat %0d want wr@1 addr 04 data deadbeef lat 2", wrc, wadr, wdat, lat);
    end
    xact(0, 2'b10, 0, 10'h010, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (rd !== 32'hDEADBEEF || lat !== 3 || rdc !== 1) begin
      nerr++; $display("FAIL word_load: got %h lat %0d rd@%0d want deadbeef lat 3 rd@1", rd, lat, rdc);
    end
    preload(8'h04, 32'h11223344);
    xact(1, 2'b00, 0, 10'h012, 32'h000000AA, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    model_store(10'h012, 2'b00, 32'hAA);
    nvec++;
    if (wdat !== 32'h11AA3344 || wrc !== 3 || lat !== 4 || rdc !== 1) begin
      nerr++; $display("FAIL byte_store: got %h wr@%0d lat %0d want 11aa3344 wr@3 lat 4", wdat, wrc, lat);
    end
    preload(8'h05, 32'h80F17F00);
    xact(0, 2'b00, 0, 10'h015, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (rd !== 32'h0000007F) begin nerr++; $display("FAIL lb_off1: got %h want 0000007f", rd); end
    xact(0, 2'b00, 0, 10'h016, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (rd !== 32'hFFFFFFF1) begin nerr++; $display("FAIL lb_off2: got %h want fffffff1", rd); end
    xact(0, 2'b00, 1, 10'h016, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (rd !== 32'h000000F1) begin nerr++; $display("FAIL lbu_off2: got %h want 000000f1", rd); end
    xact(0, 2'b01, 0, 10'h016, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (rd !== 32'hFFFF80F1) begin nerr++; $display("FAIL lh_off2: got %h want ffff80f1", rd); end
  endtask

  task automatic test_misalign();
    int lat, rdc, wrc; logic [31:0] rd, wdat; logic err; logic [7:0] radr, wadr; bit ovl;
    preload(8'h04, 32'h5A6B7C8D);
    xact(0, 2'b10, 0, 10'h013, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (MIS_EN) begin
      if (lat !== 1 || err !== 1'b1 || rdc !== -1 || rd !== 32'd0) begin
        nerr++; $display("FAIL misalign_trap: got lat %0d err %b rd@%0d data %h want lat 1 err 1 no read 0", lat, err, rdc, rd);
      end
    end else begin
      if (lat !== 3 || err !== 1'b0 || rdc !== 1 || radr !== 8'h04 || rd !== 32'h5A6B7C8D) begin
        nerr++; $display("FAIL misalign_pass: got lat %0d err %b addr %h data %h want lat 3 err 0 addr 04 5a6b7c8d", lat, err, radr, rd);
      end
    end
  endtask

  task automatic test_random();
    int lat, rdc, wrc, elat, erdc, ewrc; logic [31:0] rd, wdat, erd; logic err; logic [7:0] radr, wadr; bit ovl;
    bit st, un, mis; logic [1:0] sz; logic [9:0] a; logic [31:0] wd;
    for (int k = 0; k < 200; k++) begin
      st = 1'($urandom); un = 1'($urandom); sz = 2'($urandom); a = 10'($urandom); wd = $urandom;
      mis = MIS_EN && misaligned(a, sz);
      erd = (!st && !mis) ? exp_load(a, sz, un) : 32'd0;
      if (mis)          begin elat = 1; erdc = -1; ewrc = -1; end
      else if (!st)     begin elat = 3; erdc = 1;  ewrc = -1; end
      else if (sz[1])   begin elat = 2; erdc = -1; ewrc = 1;  end
      else              begin elat = 4; erdc = 1;  ewrc = 3;  end
      xact(st, sz, un, a, wd, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
      if (st && !mis) model_store(a, sz, wd);
      nvec++;
      if (lat !== elat || rdc !== erdc || wrc !== ewrc || ovl) begin
        nerr++; $display("FAIL rnd_timing #%0d: got lat %0d rd@%0d wr@%0d ovl %b want %0d %0d %0d 0", k, lat, rdc, wrc, ovl, elat, erdc, ewrc);
      end
      nvec++;
      if (rd !== erd || err !== mis) begin
        nerr++; $display("FAIL rnd_resp #%0d a=%h sz=%0d: got %h err %b want %h err %b", k, a, sz, rd, err, erd, mis);
      end
      if (erdc > 0) begin
        nvec++;
        if (radr !== a[9:2]) begin nerr++; $display("FAIL rnd_raddr #%0d: got %h want %h", k, radr, a[9:2]); end
      end
      if (ewrc > 0) begin
        nvec++;
        if (wadr !== a[9:2] || wdat !== word_at(a)) begin
          nerr++; $display("FAIL rnd_write #%0d: got %h@%h want %h@%h", k, wdat, wadr, word_at(a), a[9:2]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ca, cb; bit bad_rdy, ovl; logic rdy_at, rv;
    logic [9:0] a; logic [31:0] wd, erd, rd;
    a = {8'($urandom), 2'b00}; wd = $urandom;
    ca = -1; cb = -1; bad_rdy = 0; ovl = 0; rdy_at = 0; rd = 32'hx;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    model_store(a, 2'b10, wd);
    erd = exp_load(a, 2'b10, 1'b0);
    bus.req_store = 1'b0; bus.req_wdata = 32'h0;
    for (int c = 1; c <= 8 && ca < 0; c++) begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_write) ovl = 1;
      if (bus.resp_valid) begin ca = c; rdy_at = bus.req_ready; end
      else if (bus.req_ready) bad_rdy = 1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8 && cb < 0; c++) begin
      @(negedge clk);
      rv = bus.resp_valid;
      if (bus.mem_read && bus.mem_write) ovl = 1;
      if (rv) begin cb = c; rd = bus.resp_rdata; end
      else if (bus.req_ready) bad_rdy = 1;
    end
    nvec++;
    if (ca !== 2 || rdy_at !== 1'b1 || bad_rdy || ovl) begin
      nerr++; $display("FAIL b2b_first: got resp@%0d ready %b busy_ready %b ovl %b want resp@2 ready 1 0 0", ca, rdy_at, bad_rdy, ovl);
    end
    nvec++;
    if (cb !== 3 || rd !== erd) begin
      nerr++; $display("FAIL b2b_second: got resp@%0d data %h want resp@3 data %h", cb, rd, erd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rdc, wrc; logic [31:0] rd, wdat; logic err; logic [7:0] radr, wadr; bit ovl, seen;
    preload(8'h21, 32'hCAFEF00D);
    xact(0, 2'b10, 0, 10'h084, 32'h0, lat, rdc, wrc, rd, err, radr, wadr, wdat, ovl);
    nvec++;
    if (rd !== 32'hCAFEF00D) begin nerr++; $display("FAIL pre_rst_load: got %h want cafef00d", rd); end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'b10; bus.req_addr = 10'h084;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    seen = bus.resp_valid;
    nvec++;
    if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL ready_in_rst: got %b want 0", bus.req_ready); end
    rst = 1'b0;
    @(negedge clk);
    seen = seen | bus.resp_valid;
    nvec++;
    if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL ready_post_rst: got %b want 1", bus.req_ready); end
    nvec++;
    if ({bus.resp_rdata, bus.mem_wdata, bus.mem_addr, bus.resp_err, bus.mem_read, bus.mem_write} !== 75'd0) begin
      nerr++; $display("FAIL outs_post_rst: got %h/%h/%h/%b%b%b want 0", bus.resp_rdata, bus.mem_wdata, bus.mem_addr, bus.resp_err, bus.mem_read, bus.mem_write);
    end
    repeat (3) begin @(negedge clk); seen = seen | bus.resp_valid; end
    nvec++;
    if (seen !== 1'b0) begin nerr++; $display("FAIL dropped_resp: got resp_valid %b want 0", seen); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'd0;
    test_reset();
    for (int w = 0; w < 256; w++) preload(8'(w), $urandom);
    test_directed();
    test_misalign();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting between the CPU execute stage and the word-wide data memory. It accepts byte, halfword and word load/store requests on byte addresses and drives the memory's read/write port. It performs read-modify-write for sub-word stores, because the memory has no byte enables, and returns sign- or zero-extended load data through a single-cycle response pulse.

## Interface
- ADDR_W, 10, byte-address width; memory word address is ADDR_W-2 bits (8 at default)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  qualified by resp_valid (see Configuration)
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W-2  word address, req_addr[ADDR_W-1:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, valid the cycle after mem_read

## Operation
- FSM states: IDLE, RD, LD, MRG, WR.
- req_ready = (state == IDLE) & !rst. Request fields are captured at acceptance; later input changes are ignored.
- mem_read is 1 only in RD. mem_write is 1 only in WR. Both are decoded from the state register, with no combinational path from req_*. mem_addr and mem_wdata are registered and hold their values between accesses.
- Load: IDLE -> RD -> LD -> IDLE. In LD, extract the lane from mem_rdata and extend it, then register the result into resp_rdata.
- Word store: IDLE -> WR -> IDLE. mem_wdata = req_wdata.
- Sub-word store: IDLE -> RD -> MRG -> WR -> IDLE. In MRG, replace the addressed lane(s) of mem_rdata with req_wdata[7:0] or [15:0] and register the result into mem_wdata.
- Byte order is little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword lane occupies bits [16*addr[1]+15 : 16*addr[1]].
- Extension: a byte extends from bit 7 and a halfword from bit 15. When req_unsigned=1, the upper bits are 0.
- resp_valid pulses in the first IDLE cycle after completion. resp_rdata and resp_err hold their values until the next pulse.
- A new request may be accepted in the same cycle resp_valid is high.
- Reset values:
  - req_ready 0 while rst=1, 1 after.
  - resp_valid, resp_err, mem_read, mem_write = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
  - state IDLE.
- Reset mid-operation: the in-flight request is dropped and no response is produced. A WR cycle coinciding with the rst edge still writes, because memory samples mem_write on that edge.

## Timing
Request accepted at edge ending cycle 0:
- Load: mem_read in cycle 1, resp_valid in cycle 3 (latency 3).
- Word store: mem_write in cycle 1, resp_valid in cycle 2 (latency 2).
- Sub-word store: mem_read in cycle 1, mem_write in cycle 3, resp_valid in cycle 4 (latency 4).
- Maximum throughput is one request per latency; there is no overlap between requests.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned request (halfword with addr[0]=1, or word with addr[1:0]!=0) is accepted but generates no memory strobe.
  - The FSM goes IDLE -> IDLE, and resp_valid=1, resp_err=1, resp_rdata=0 in cycle 1.
- Undefined:
  - resp_err is tied to 0.
  - A halfword ignores addr[0]; a word ignores addr[1:0].
  - The access proceeds as aligned.

## Test plan
- Word store 0xDEADBEEF at 0x010, then word load at 0x010 -> mem_write in cycle 1 with mem_addr=0x04; load returns resp_rdata=0xDEADBEEF at latency 3.
- Memory word 0x04 = 0x11223344; byte store 0xAA at 0x012 -> mem_wdata=0x11AA3344, mem_write in cycle 3, resp_valid in cycle 4.
- Memory word = 0x80F17F00; byte loads at offsets 1, 2 (signed) and 2 (unsigned) -> 0x0000007F, 0xFFFFFFF1, 0x000000F1; signed halfword at offset 2 -> 0xFFFF80F1.
- Back-to-back requests with req_valid held high -> req_ready=0 in busy cycles; the second request is accepted in the resp_valid cycle of the first; no strobe overlap.
- rst asserted in a load's LD cycle -> no resp_valid, req_ready=1 on the cycle after rst deasserts, and all outputs at their reset values.
- Word load at 0x013 -> with LSU_MISALIGN_TRAP_EN: resp_err=1 in cycle 1, no mem_read; without: reads word 0x04, resp_err=0.
